sumador_restador_serial: RTL and testbench



---
 rtl/sumres_pkg.sv | 26 ++
 rtl/sumador_completo_1bit.sv | 19 +
 rtl/sumador_restador_serial.sv | 140 ++++++++++++++
 tb/tb_sumador_restador_serial.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sumres_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sumres_pkg
// Purpose  : Shared types and constants for the bit-serial adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package sumres_pkg;

  // Sequencer states of the serial datapath
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Cin doubles as the operation select
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bit counter width; never narrower than one bit
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sumador_completo_1bit.sv
`default_nettype none
// ============================================================================
// Module   : sumador_completo_1bit
// Purpose  : Combinational one-bit full adder cell used by the serial datapath.
// Revision : 1.0 - initial release
// ============================================================================
module sumador_completo_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/sumador_restador_serial.sv
`default_nettype none
// ============================================================================
// Module   : sumador_restador_serial
// Purpose  : Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per
//            clock through a single full-adder cell, behind a start/busy/done
//            handshake. Cin=0 adds, Cin=1 computes A + ~B + 1.
// Options  : SUMRES_OVF_EN - adds the 'ovf' signed-overflow result port.
// Revision : 1.0 - initial release
// ============================================================================
module sumador_restador_serial
  import sumres_pkg::*;
#(
  parameter int WIDTH = 4  // legal range 2..16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SUMRES_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;   // low result bits collected so far
  logic [WIDTH-1:0] res_cat;  // result bits including the one produced now
  logic             carry;
  logic [CW-1:0]    count;

  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  // A request is only honoured when no operation is in flight
  assign accept   = start && (state != SHIFT);
  assign last_bit = (state == SHIFT) && (count == LAST);
  assign res_cat  = {fa_s, res_sr};

  sumador_completo_1bit u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? SHIFT : IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operand shift registers, running carry and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= (Cin == MODE_SUB) ? ~B : B;
      carry  <= (Cin == MODE_SUB);
      count  <= '0;
      res_sr <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_co;
      res_sr <= res_cat[WIDTH-1:1];
      count  <= count + CW'(1);
    end
  end

  // Result capture on the final bit; held until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      S    <= '0;
      Cout <= 1'b0;
`ifdef SUMRES_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (last_bit) begin
      S    <= res_cat;
      Cout <= fa_co;
`ifdef SUMRES_OVF_EN
      // carry into the MSB cell differs from carry out of it
      ovf  <= carry ^ fa_co;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sumador_restador_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sumador_restador_serial
// Purpose  : Self-checking bench for sumador_restador_serial (WIDTH=4) using
//            a result scoreboard. Honors SUMRES_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sumador_restador_serial;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
`ifdef SUMRES_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  sumador_restador_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
`ifdef SUMRES_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the parallel formulation
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = cin ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
    r.s  = full[W-1:0];
    r.co = full[W];
    r.ov = (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("S", {28'd0, S}, {28'd0, e.s});
        chk("Cout", {31'd0, Cout}, {31'd0, e.co});
`ifdef SUMRES_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
      end
    end
    prev_done = rst ? 1'b0 : done;
  end

  // Issue one operation at a negedge (IDLE or DONE state) and wait for done
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit poke_busy);
    int n;
    start = 1'b1;
    A     = a;
    B     = b;
    Cin   = cin;
    q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Cin   = 1'($urandom);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_after_accept", {31'd0, busy}, 32'd1);
      if (done) begin
        n = i;
        break;
      end
      if (poke_busy && i == 2) begin
        start = 1'b1;
        A     = 4'd9;
        Cin   = 1'b0;
      end
      if (i == 3) start = 1'b0;
    end
    chk("latency", n, W + 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_S", {28'd0, S}, 32'd0);
    chk("rst_Cout", {31'd0, Cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add from IDLE, then done must drop
    run_op(4'd3, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_low_after", {31'd0, done}, 32'd0);
    chk("busy_low_idle", {31'd0, busy}, 32'd0);
    chk("S_held_idle", {28'd0, S}, 32'd4);

    // Subtract equal, add zero, wrap-around cases (back-to-back)
    run_op(4'd1, 4'd1, 1'b1, 1'b0);
    run_op(4'd1, 4'd0, 1'b0, 1'b0);
    run_op(4'd15, 4'd1, 1'b0, 1'b0);
    run_op(4'd0, 4'd1, 1'b1, 1'b0);

    // Start pulsed while busy must be ignored
    run_op(4'd3, 4'd1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);

    // Back-to-back: second start presented in the DONE cycle
    run_op(4'd5, 4'd5, 1'b0, 1'b0);
    run_op(4'd2, 4'd2, 1'b0, 1'b0);
    @(negedge clk);

    // Reset during the second SHIFT cycle aborts the operation
    start = 1'b1;
    A     = 4'd7;
    B     = 4'd3;
    Cin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_S", {28'd0, S}, 32'd0);
    chk("abort_Cout", {31'd0, Cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(4'd5, 4'd2, 1'b1, 1'b0);

    // Signed-overflow corner cases
    run_op(4'd7, 4'd1, 1'b0, 1'b0);
    run_op(4'd8, 4'd1, 1'b1, 1'b0);
    run_op(4'd3, 4'd1, 1'b0, 1'b0);

    // Exhaustive sweep of both modes
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(W'(a), W'(b), 1'(c), 1'b0);
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
